// File: rtl/sdram_types.sv
// Shared SDRAM type definitions.
// Holds the command enum and the FIFO command word that the IO engine drains.
// Also holds the default address widths and the packed request address layout.
package sdram_types;

  localparam int SDRAM_ROW_W = 13;
  localparam int SDRAM_COL_W = 9;

  typedef enum logic [2:0] {
    NOP   = 3'd0,
    PALL  = 3'd1,
    REF   = 3'd2,
    MRS   = 3'd3,
    ACT   = 3'd4,
    PRE   = 3'd5,
    READ  = 3'd6,
    WRITE = 3'd7
  } cmd_t;

  typedef struct packed {
    logic [SDRAM_COL_W-1:0] column;
    logic [15:0]            data;
  } cmd_payload_t;

  // Command FIFO word: {cmd, ba, d.column, d.data}
  typedef struct packed {
    cmd_t         cmd;
    logic [1:0]   ba;
    cmd_payload_t d;
  } data_t;

  // Request address layout: {row, bank, column}
  typedef struct packed {
    logic [SDRAM_ROW_W-1:0] row;
    logic [1:0]             ba;
    logic [SDRAM_COL_W-1:0] column;
  } sdram_addr_t;

endpackage

// File: rtl/sdram_cmd_gen_if.sv
// Request and command-FIFO bus of the SDRAM command generator.
//   req_valid/req_ready/req_we/req_addr/req_data/req_id : single-word request channel
//   fifo_full/fifo_wrreq/fifo_in                         : producer side of the command FIFO
// The slave modport is the command generator's view; master is the client/FIFO side.
interface sdram_cmd_gen_if #(
  parameter int ROW_W = sdram_types::SDRAM_ROW_W,
  parameter int COL_W = sdram_types::SDRAM_COL_W
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [ROW_W+2+COL_W-1:0] req_addr;
  logic [15:0]              req_data;
  logic [1:0]               req_id;
  logic                     fifo_full;
  logic                     fifo_wrreq;
  sdram_types::data_t       fifo_in;

  modport slave (
    input  req_valid, req_we, req_addr, req_data, req_id, fifo_full,
    output req_ready, fifo_wrreq, fifo_in
  );

  modport master (
    output req_valid, req_we, req_addr, req_data, req_id, fifo_full,
    input  req_ready, fifo_wrreq, fifo_in
  );
endinterface

// File: rtl/sdram_bank_tracker.sv
// Open-row tracker for the four SDRAM banks.
//   clk, srst          : clock, synchronous active-high reset
//   bank, row          : bank/row of the current request
//   open_stb           : mark bank open with row (ACT issued)
//   close_stb          : mark bank closed (PRE issued)
//   close_all          : close every bank (PALL issued)
//   hit, miss, closed  : status of the requested bank (combinational)
//   any_open           : at least one bank is open
module sdram_bank_tracker #(
  parameter int ROW_W = 13
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [1:0]       bank,
  input  logic [ROW_W-1:0] row,
  input  logic             open_stb,
  input  logic             close_stb,
  input  logic             close_all,
  output logic             hit,
  output logic             miss,
  output logic             closed,
  output logic             any_open
);

  logic [3:0] open_vec;
  logic [3:0] row_eq;

  for (genvar gi = 0; gi < 4; gi++) begin : g_bank
    logic             open_reg;
    logic [ROW_W-1:0] row_reg;
    logic             sel;

    assign sel = (bank == 2'(gi));

    always_ff @(posedge clk) begin
      if (srst) begin
        open_reg <= 1'b0;
        row_reg  <= '0;
      end else begin
        if (close_all) begin
          open_reg <= 1'b0;
        end else if (open_stb && sel) begin
          open_reg <= 1'b1;
        end else if (close_stb && sel) begin
          open_reg <= 1'b0;
        end
        if (open_stb && sel) begin
          row_reg <= row;
        end
      end
    end

    assign open_vec[gi] = open_reg;
    assign row_eq[gi]   = (row_reg == row);
  end

  assign hit      = open_vec[bank] & row_eq[bank];
  assign miss     = open_vec[bank] & ~row_eq[bank];
  assign closed   = ~open_vec[bank];
  assign any_open = |open_vec;

endmodule

// File: rtl/sdram_cmd_gen.sv
// SDRAM command generator: producer side of the command FIFO.
// Runs the power-up PALL/REF/MRS sequence, periodic auto-refresh and turns
// single-word read/write requests into PRE/ACT/READ/WRITE words, tracking the
// open row per bank. Timing (tRCD/tRP/tRC) is enforced downstream.
//   clkSDRAM  : controller clock
//   reset     : synchronous active-high reset
//   icnt_ovf  : one-cycle pulse from the init/refresh counter
//   init_done : initialisation sequence complete
//   bus       : request channel + command FIFO write port (slave modport)
module sdram_cmd_gen
  import sdram_types::*;
#(
  parameter int ROW_W     = SDRAM_ROW_W,
  parameter int COL_W     = SDRAM_COL_W,
  parameter int INIT_REFS = 8
) (
  input  logic            clkSDRAM,
  input  logic            reset,
  input  logic            icnt_ovf,
  output logic            init_done,
  sdram_cmd_gen_if.slave  bus
);

  localparam logic [3:0] ST_WAIT_INIT = 4'd0;
  localparam logic [3:0] ST_INIT_PALL = 4'd1;
  localparam logic [3:0] ST_INIT_REF  = 4'd2;
  localparam logic [3:0] ST_INIT_MRS  = 4'd3;
  localparam logic [3:0] ST_IDLE      = 4'd4;
  localparam logic [3:0] ST_PRE       = 4'd5;
  localparam logic [3:0] ST_ACT       = 4'd6;
  localparam logic [3:0] ST_RW        = 4'd7;
  localparam logic [3:0] ST_REF_PALL  = 4'd8;
  localparam logic [3:0] ST_REF_REF   = 4'd9;

  logic [3:0] state_reg, state_next;
  logic [3:0] ref_cnt_reg, ref_cnt_next;
  logic       refresh_pending_reg, refresh_pending_next;
  logic       init_done_reg, init_done_next;

  logic             cmd_state;
  logic             wr;
  data_t            fifo_word;
  logic [1:0]       req_bank;
  logic [ROW_W-1:0] req_row;
  logic [COL_W-1:0] req_col;
  logic             bank_hit, bank_miss, bank_closed, any_open;

  assign req_col  = bus.req_addr[COL_W-1:0];
  assign req_bank = bus.req_addr[COL_W +: 2];
  assign req_row  = bus.req_addr[COL_W+2 +: ROW_W];

  // Every state except WAIT_INIT and IDLE emits exactly one FIFO word.
  assign cmd_state = (state_reg != ST_WAIT_INIT) && (state_reg != ST_IDLE);
  // Gated by reset so no word escapes in the cycle reset is asserted.
  assign wr        = cmd_state & ~bus.fifo_full & ~reset;

  assign bus.fifo_wrreq = wr;
  assign bus.req_ready  = wr && (state_reg == ST_RW);
  assign bus.fifo_in    = fifo_word;
  assign init_done      = init_done_reg;

  sdram_bank_tracker #(.ROW_W(ROW_W)) tracker (
    .clk       (clkSDRAM),
    .srst      (reset),
    .bank      (req_bank),
    .row       (req_row),
    .open_stb  (wr && (state_reg == ST_ACT)),
    .close_stb (wr && (state_reg == ST_PRE)),
    .close_all (wr && (state_reg == ST_REF_PALL)),
    .hit       (bank_hit),
    .miss      (bank_miss),
    .closed    (bank_closed),
    .any_open  (any_open)
  );

  // Word decode; request fields are held stable by the client until accepted.
  always_comb begin
    fifo_word = '0;
    case (state_reg)
      ST_INIT_PALL, ST_REF_PALL: fifo_word.cmd = PALL;
      ST_INIT_REF, ST_REF_REF:   fifo_word.cmd = REF;
      ST_INIT_MRS:               fifo_word.cmd = MRS;
      ST_ACT: begin
        fifo_word.cmd    = ACT;
        fifo_word.ba     = req_bank;
        fifo_word.d.data = 16'(req_row);
      end
      ST_PRE: begin
        fifo_word.cmd = PRE;
        fifo_word.ba  = req_bank;
      end
      ST_RW: begin
        fifo_word.cmd      = bus.req_we ? WRITE : READ;
        fifo_word.ba       = req_bank;
        fifo_word.d.column = SDRAM_COL_W'(req_col);
        fifo_word.d.data   = bus.req_we ? bus.req_data : {14'b0, bus.req_id};
      end
      default: fifo_word = '0;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    ref_cnt_next = ref_cnt_reg;
    case (state_reg)
      ST_WAIT_INIT: if (icnt_ovf) state_next = ST_INIT_PALL;
      ST_INIT_PALL: if (wr) begin
        state_next   = ST_INIT_REF;
        ref_cnt_next = 4'd0;
      end
      ST_INIT_REF: if (wr) begin
        if (ref_cnt_reg == 4'(INIT_REFS - 1)) state_next = ST_INIT_MRS;
        else ref_cnt_next = ref_cnt_reg + 4'd1;
      end
      ST_INIT_MRS: if (wr) state_next = ST_IDLE;
      ST_IDLE: begin
        // A pending refresh always wins over a waiting request.
        if (refresh_pending_reg) state_next = any_open ? ST_REF_PALL : ST_REF_REF;
        else if (bus.req_valid) begin
          if (bank_hit)         state_next = ST_RW;
          else if (bank_miss)   state_next = ST_PRE;
          else if (bank_closed) state_next = ST_ACT;
        end
      end
      ST_PRE:      if (wr) state_next = ST_ACT;
      ST_ACT:      if (wr) state_next = ST_RW;
      ST_RW:       if (wr) state_next = ST_IDLE;
      ST_REF_PALL: if (wr) state_next = ST_REF_REF;
      ST_REF_REF:  if (wr) state_next = ST_IDLE;
      default:     state_next = ST_WAIT_INIT;
    endcase
  end

  // Single pending bit: a pulse while already pending (including the REF
  // write cycle itself) is dropped. Pulses before init_done are ignored.
  always_comb begin
    refresh_pending_next = refresh_pending_reg | (init_done_reg & icnt_ovf);
    if (wr && (state_reg == ST_REF_REF)) refresh_pending_next = 1'b0;
    init_done_next = init_done_reg | (wr && (state_reg == ST_INIT_MRS));
  end

  always_ff @(posedge clkSDRAM) begin
    if (reset) begin
      state_reg           <= ST_WAIT_INIT;
      ref_cnt_reg         <= 4'd0;
      refresh_pending_reg <= 1'b0;
      init_done_reg       <= 1'b0;
    end else begin
      state_reg           <= state_next;
      ref_cnt_reg         <= ref_cnt_next;
      refresh_pending_reg <= refresh_pending_next;
      init_done_reg       <= init_done_next;
    end
  end

endmodule

// File: tb/tb_sdram_cmd_gen.sv
// Self-checking bench for sdram_cmd_gen: table of single requests plus
// hand-written sequences for init, refresh, FIFO back-pressure and reset.
module tb_sdram_cmd_gen;
  import sdram_types::*;

  localparam int ROW_W     = 13;
  localparam int COL_W     = 9;
  localparam int INIT_REFS = 8;

  logic clk, reset, icnt_ovf, init_done;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rdy_cnt = 0;

  data_t got_q[$];
  int    got_cyc[$];
  data_t exp_q[$];

  typedef struct packed {
    logic        we;
    logic [1:0]  bank;
    logic [12:0] row;
    logic [8:0]  col;
    logic [15:0] data;
    logic [1:0]  id;
    logic [3:0]  lat;
    logic [1:0]  n;
    data_t       w0;
    data_t       w1;
    data_t       w2;
  } vec_t;

  vec_t vecs [7];

  sdram_cmd_gen_if #(.ROW_W(ROW_W), .COL_W(COL_W)) bus ();

  sdram_cmd_gen #(.ROW_W(ROW_W), .COL_W(COL_W), .INIT_REFS(INIT_REFS)) dut (
    .clkSDRAM  (clk),
    .reset     (reset),
    .icnt_ovf  (icnt_ovf),
    .init_done (init_done),
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO capture and req_ready pulse counting, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.fifo_wrreq === 1'b1) begin
      got_q.push_back(bus.fifo_in);
      got_cyc.push_back(cyc);
    end
    if (bus.req_ready === 1'b1) rdy_cnt <= rdy_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic data_t mk(cmd_t c, logic [1:0] ba, logic [8:0] col, logic [15:0] d);
    data_t w;
    w.cmd      = c;
    w.ba       = ba;
    w.d.column = col;
    w.d.data   = d;
    return w;
  endfunction

  function automatic vec_t mkvec(logic we, logic [1:0] bank, logic [12:0] row, logic [8:0] col,
                                 logic [15:0] data, logic [1:0] id, int lat, int n,
                                 data_t w0, data_t w1, data_t w2);
    vec_t v;
    v.we = we; v.bank = bank; v.row = row; v.col = col; v.data = data; v.id = id;
    v.lat = 4'(lat); v.n = 2'(n); v.w0 = w0; v.w1 = w1; v.w2 = w2;
    return v;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clear_got();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic check_words(input string name);
    chk({name, " word count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s word%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
    exp_q.delete();
  endtask

  task automatic drive_req(input logic we, input logic [1:0] bank, input logic [12:0] row,
                           input logic [8:0] col, input logic [15:0] data, input logic [1:0] id);
    sdram_addr_t a;
    a.row = row; a.ba = bank; a.column = col;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_data  = data;
    bus.req_id    = id;
    bus.req_valid = 1'b1;
  endtask

  // Called #1 after a posedge. lat = negedges from driving req_valid to req_ready.
  task automatic do_req(input logic we, input logic [1:0] bank, input logic [12:0] row,
                        input logic [8:0] col, input logic [15:0] data, input logic [1:0] id,
                        input bit ovf, output int lat, output int pulses);
    int r0;
    bit found;
    r0 = rdy_cnt;
    clear_got();
    found = 1'b0;
    lat = 0;
    drive_req(we, bank, row, col, data, id);
    icnt_ovf = ovf;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) begin
        lat = k;
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      icnt_ovf = 1'b0;
    end
    if (found) begin
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    icnt_ovf = 1'b0;
    step(8);
    pulses = rdy_cnt - r0;
    $display("req we=%0d bank=%0d row=%h col=%h lat=%0d words=%0d ready=%0d",
             we, bank, row, col, lat, got_q.size(), pulses);
  endtask

  task automatic run_init(input string name, input bit extra_pulse);
    bit found;
    int c_done;
    clear_got();
    icnt_ovf = 1'b1;
    step(1);
    icnt_ovf = 1'b0;
    if (extra_pulse) begin
      // Pulse during INIT_REF must not leave a refresh pending.
      step(3);
      icnt_ovf = 1'b1;
      step(1);
      icnt_ovf = 1'b0;
    end
    found = 1'b0;
    c_done = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (init_done === 1'b1) begin
        found = 1'b1;
        c_done = cyc;
        break;
      end
    end
    chk({name, " init_done rise"}, 64'(found), 64'd1);
    step(10);
    if (got_cyc.size() >= INIT_REFS + 2) begin
      chk({name, " consecutive"}, 64'(got_cyc[INIT_REFS+1] - got_cyc[0]), 64'(INIT_REFS + 1));
      chk({name, " init_done on MRS"}, 64'(c_done), 64'(got_cyc[INIT_REFS+1] + 1));
    end
    exp_q.push_back(mk(PALL, 2'd0, 9'd0, 16'd0));
    for (int i = 0; i < INIT_REFS; i++) exp_q.push_back(mk(REF, 2'd0, 9'd0, 16'd0));
    exp_q.push_back(mk(MRS, 2'd0, 9'd0, 16'd0));
    $display("init %s words=%0d init_done=%0d", name, got_q.size(), init_done);
    check_words(name);
  endtask

  initial begin
    int lat, pulses, r0;
    bit found;

    reset = 1'b1;
    icnt_ovf = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_data = '0;
    bus.req_id = '0;
    bus.fifo_full = 1'b0;

    // Reset state
    step(2);
    @(negedge clk);
    chk("reset fifo_wrreq", 64'(bus.fifo_wrreq), 64'd0);
    chk("reset req_ready", 64'(bus.req_ready), 64'd0);
    chk("reset init_done", 64'(init_done), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(5);
    chk("wait_init no words", 64'(got_q.size()), 64'd0);
    chk("wait_init init_done", 64'(init_done), 64'd0);

    run_init("init", 1'b1);

    // Request table
    vecs[0] = mkvec(1'b0, 2'd1, 13'h0123, 9'h040, 16'h0000, 2'd2, 3, 2,
                    mk(ACT, 2'd1, 9'd0, 16'h0123), mk(READ, 2'd1, 9'h040, 16'h0002), '0);
    vecs[1] = mkvec(1'b1, 2'd1, 13'h0123, 9'h041, 16'hBEEF, 2'd0, 2, 1,
                    mk(WRITE, 2'd1, 9'h041, 16'hBEEF), '0, '0);
    vecs[2] = mkvec(1'b1, 2'd1, 13'h0200, 9'h010, 16'h1234, 2'd0, 4, 3,
                    mk(PRE, 2'd1, 9'd0, 16'd0), mk(ACT, 2'd1, 9'd0, 16'h0200),
                    mk(WRITE, 2'd1, 9'h010, 16'h1234));
    vecs[3] = mkvec(1'b0, 2'd2, 13'h1FFF, 9'h1FF, 16'h0000, 2'd3, 3, 2,
                    mk(ACT, 2'd2, 9'd0, 16'h1FFF), mk(READ, 2'd2, 9'h1FF, 16'h0003), '0);
    vecs[4] = mkvec(1'b0, 2'd2, 13'h1FFF, 9'h000, 16'h0000, 2'd0, 2, 1,
                    mk(READ, 2'd2, 9'h000, 16'h0000), '0, '0);
    vecs[5] = mkvec(1'b1, 2'd1, 13'h0200, 9'h1FF, 16'hFFFF, 2'd0, 2, 1,
                    mk(WRITE, 2'd1, 9'h1FF, 16'hFFFF), '0, '0);
    vecs[6] = mkvec(1'b0, 2'd0, 13'h0000, 9'h000, 16'h0000, 2'd1, 3, 2,
                    mk(ACT, 2'd0, 9'd0, 16'h0000), mk(READ, 2'd0, 9'h000, 16'h0001), '0);

    for (int v = 0; v < 7; v++) begin
      do_req(vecs[v].we, vecs[v].bank, vecs[v].row, vecs[v].col, vecs[v].data, vecs[v].id,
             1'b0, lat, pulses);
      chk($sformatf("vec%0d latency", v), 64'(lat), 64'(vecs[v].lat));
      chk($sformatf("vec%0d ready pulses", v), 64'(pulses), 64'd1);
      if (vecs[v].n >= 2'd1) exp_q.push_back(vecs[v].w0);
      if (vecs[v].n >= 2'd2) exp_q.push_back(vecs[v].w1);
      if (vecs[v].n >= 2'd3) exp_q.push_back(vecs[v].w2);
      check_words($sformatf("vec%0d", v));
    end

    // Refresh with banks open, then a read to bank 1: PALL, REF, ACT, READ
    icnt_ovf = 1'b1;
    step(1);
    icnt_ovf = 1'b0;
    do_req(1'b0, 2'd1, 13'h0200, 9'h005, 16'h0000, 2'd1, 1'b0, lat, pulses);
    chk("refresh-open latency", 64'(lat), 64'd6);
    chk("refresh-open ready pulses", 64'(pulses), 64'd1);
    exp_q.push_back(mk(PALL, 2'd0, 9'd0, 16'd0));
    exp_q.push_back(mk(REF, 2'd0, 9'd0, 16'd0));
    exp_q.push_back(mk(ACT, 2'd1, 9'd0, 16'h0200));
    exp_q.push_back(mk(READ, 2'd1, 9'h005, 16'h0001));
    check_words("refresh-open");

    // icnt_ovf together with req_valid in IDLE: request first, then refresh
    do_req(1'b1, 2'd0, 13'h0007, 9'h003, 16'hA5A5, 2'd0, 1'b1, lat, pulses);
    chk("simul latency", 64'(lat), 64'd3);
    chk("simul ready pulses", 64'(pulses), 64'd1);
    exp_q.push_back(mk(ACT, 2'd0, 9'd0, 16'h0007));
    exp_q.push_back(mk(WRITE, 2'd0, 9'h003, 16'hA5A5));
    exp_q.push_back(mk(PALL, 2'd0, 9'd0, 16'd0));
    exp_q.push_back(mk(REF, 2'd0, 9'd0, 16'd0));
    check_words("simul");

    // All banks closed: single REF
    clear_got();
    icnt_ovf = 1'b1;
    step(1);
    icnt_ovf = 1'b0;
    step(6);
    $display("refresh-closed words=%0d", got_q.size());
    exp_q.push_back(mk(REF, 2'd0, 9'd0, 16'd0));
    check_words("refresh-closed");

    // Three back-to-back pulses: the 2nd/3rd arrive while pending and are dropped
    clear_got();
    icnt_ovf = 1'b1;
    step(3);
    icnt_ovf = 1'b0;
    step(6);
    $display("refresh-drop words=%0d", got_q.size());
    exp_q.push_back(mk(REF, 2'd0, 9'd0, 16'd0));
    check_words("refresh-drop");

    // FIFO full held for 5 cycles during ACT
    clear_got();
    r0 = rdy_cnt;
    bus.fifo_full = 1'b1;
    drive_req(1'b0, 2'd3, 13'h0055, 9'h022, 16'h0000, 2'd1);
    step(1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("full%0d fifo_wrreq", k), 64'(bus.fifo_wrreq), 64'd0);
      chk($sformatf("full%0d fifo_in", k), 64'(bus.fifo_in), 64'(mk(ACT, 2'd3, 9'd0, 16'h0055)));
      @(posedge clk);
      #1;
    end
    bus.fifo_full = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk("full ready seen", 64'(found), 64'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    step(4);
    $display("full-stall words=%0d ready=%0d", got_q.size(), rdy_cnt - r0);
    chk("full ready pulses", 64'(rdy_cnt - r0), 64'd1);
    exp_q.push_back(mk(ACT, 2'd3, 9'd0, 16'h0055));
    exp_q.push_back(mk(READ, 2'd3, 9'h022, 16'h0001));
    check_words("full-stall");

    // Reset asserted while in ACT
    clear_got();
    r0 = rdy_cnt;
    drive_req(1'b0, 2'd0, 13'h0001, 9'h000, 16'h0000, 2'd0);
    step(1);
    reset = 1'b1;
    @(negedge clk);
    chk("reset-in-ACT fifo_wrreq", 64'(bus.fifo_wrreq), 64'd0);
    step(2);
    reset = 1'b0;
    bus.req_valid = 1'b0;
    step(5);
    $display("reset-in-ACT words=%0d ready=%0d init_done=%0d", got_q.size(), rdy_cnt - r0, init_done);
    chk("reset-in-ACT words", 64'(got_q.size()), 64'd0);
    chk("reset-in-ACT ready pulses", 64'(rdy_cnt - r0), 64'd0);
    chk("reset-in-ACT init_done", 64'(init_done), 64'd0);

    run_init("reinit", 1'b0);

    // Bank 3 was open with row 0x55 before reset; it must be closed now.
    do_req(1'b0, 2'd3, 13'h0055, 9'h007, 16'h0000, 2'd2, 1'b0, lat, pulses);
    chk("post-reset latency", 64'(lat), 64'd3);
    chk("post-reset ready pulses", 64'(pulses), 64'd1);
    exp_q.push_back(mk(ACT, 2'd3, 9'd0, 16'h0055));
    exp_q.push_back(mk(READ, 2'd3, 9'h007, 16'h0002));
    check_words("post-reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
